// File: rtl/scanline_writer.sv
// rtl/scanline_writer.sv - fills the off-screen scanline VRAM bank from a pixel stream
module scanline_writer #(
    parameter int H_PIXELS        = 800,
    parameter int V_PIXELS        = 600,
    parameter int V_TOTAL         = 618,
    parameter int ADDR_WIDTH      = 10,
    parameter int V_COUNTER_WIDTH = $clog2(V_TOTAL)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       line_advance,
    input  logic                       frame_start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [7:0]                 in_data,
    input  logic                       in_last,
    output logic                       line_req,
    output logic [V_COUNTER_WIDTH-1:0] req_line,
    output logic [ADDR_WIDTH-1:0]      vram_even_wraddr,
    output logic [7:0]                 vram_even_data,
    output logic                       vram_even_we,
    output logic [ADDR_WIDTH-1:0]      vram_odd_wraddr,
    output logic [7:0]                 vram_odd_data,
    output logic                       vram_odd_we,
    input  logic                       clr_err,
    output logic                       underrun,
    output logic                       short_line,
    output logic                       long_line
);
    typedef enum logic [2:0] {WAIT_FRAME, IDLE, FILL, DRAIN, DONE} state_t;

    localparam logic [V_COUNTER_WIDTH-1:0] LAST_LINE = V_COUNTER_WIDTH'(V_TOTAL - 1);
    localparam logic [V_COUNTER_WIDTH-1:0] VIS_LINES = V_COUNTER_WIDTH'(V_PIXELS);
    localparam logic [ADDR_WIDTH-1:0]      LAST_COL  = ADDR_WIDTH'(H_PIXELS - 1);

    state_t                     state;
    state_t                     after_drain;
    logic [V_COUNTER_WIDTH-1:0] disp_line;
    logic [V_COUNTER_WIDTH-1:0] next_disp;
    logic [V_COUNTER_WIDTH-1:0] next_target;
    logic                       disp_parity;
    logic                       target_visible;
    logic                       accept;
    logic [ADDR_WIDTH-1:0]      col;

    // Display line after this line_advance, and the line to be filled behind it
    always_comb begin
        next_disp = '0;
        if (!frame_start && disp_line != LAST_LINE) begin
            next_disp = disp_line + 1'b1;
        end
        next_target = '0;
        if (next_disp != LAST_LINE) begin
            next_target = next_disp + 1'b1;
        end
    end

    assign target_visible = next_target < VIS_LINES;
    assign in_ready       = !rst && !line_advance && (state == FILL || state == DRAIN);
    assign accept         = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= WAIT_FRAME;
            after_drain      <= IDLE;
            disp_line        <= '0;
            disp_parity      <= 1'b0;
            col              <= '0;
            req_line         <= '0;
            line_req         <= 1'b0;
            vram_even_we     <= 1'b0;
            vram_even_wraddr <= '0;
            vram_even_data   <= '0;
            vram_odd_we      <= 1'b0;
            vram_odd_wraddr  <= '0;
            vram_odd_data    <= '0;
            underrun         <= 1'b0;
            short_line       <= 1'b0;
            long_line        <= 1'b0;
        end else begin
            line_req     <= 1'b0;
            vram_even_we <= 1'b0;
            vram_odd_we  <= 1'b0;

            // Later set assignments below override a same-cycle clear
            if (clr_err) begin
                underrun   <= 1'b0;
                short_line <= 1'b0;
                long_line  <= 1'b0;
            end

            if (line_advance) begin
                disp_line   <= next_disp;
                disp_parity <= frame_start ? 1'b0 : !disp_parity;
            end

            case (state)
                WAIT_FRAME: begin
                    if (line_advance && next_target == '0) begin
                        line_req <= 1'b1;
                        req_line <= '0;
                        col      <= '0;
                        state    <= FILL;
                    end
                end
                IDLE, DONE: begin
                    if (line_advance) begin
                        if (target_visible) begin
                            line_req <= 1'b1;
                            req_line <= next_target;
                            col      <= '0;
                            state    <= FILL;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                FILL: begin
                    if (line_advance) begin
                        underrun    <= 1'b1;
                        state       <= DRAIN;
                        after_drain <= target_visible ? FILL : IDLE;
                        if (target_visible) begin
                            line_req <= 1'b1;
                            req_line <= next_target;
                        end
                    end else if (accept) begin
                        // Parity 1 displays an odd line, so the even bank is off-screen
                        if (disp_parity) begin
                            vram_even_we     <= 1'b1;
                            vram_even_wraddr <= col;
                            vram_even_data   <= in_data;
                        end else begin
                            vram_odd_we     <= 1'b1;
                            vram_odd_wraddr <= col;
                            vram_odd_data   <= in_data;
                        end
                        if (col == LAST_COL) begin
                            if (in_last) begin
                                state <= DONE;
                            end else begin
                                long_line   <= 1'b1;
                                after_drain <= DONE;
                                state       <= DRAIN;
                            end
                        end else if (in_last) begin
                            short_line <= 1'b1;
                            state      <= DONE;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (line_advance) begin
                        after_drain <= target_visible ? FILL : IDLE;
                        if (target_visible) begin
                            line_req <= 1'b1;
                            req_line <= next_target;
                        end
                    end else if (accept && in_last) begin
                        col   <= '0;
                        state <= after_drain;
                    end
                end
                default: state <= WAIT_FRAME;
            endcase
        end
    end
endmodule

// File: tb/tb_scanline_writer.sv
// tb/tb_scanline_writer.sv - scoreboard bench for scanline_writer
module tb_scanline_writer;
    localparam int HP = 8;
    localparam int VP = 4;
    localparam int VT = 6;
    localparam int AW = 4;
    localparam int VW = $clog2(VT);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          line_advance = 1'b0;
    logic          frame_start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_data = 8'h00;
    logic          in_last = 1'b0;
    logic          line_req;
    logic [VW-1:0] req_line;
    logic [AW-1:0] even_addr, odd_addr;
    logic [7:0]    even_data, odd_data;
    logic          even_we, odd_we;
    logic          clr_err = 1'b0;
    logic          underrun, short_line, long_line;

    always #5 clk = ~clk;

    scanline_writer #(
        .H_PIXELS(HP), .V_PIXELS(VP), .V_TOTAL(VT), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst), .line_advance(line_advance), .frame_start(frame_start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .line_req(line_req), .req_line(req_line),
        .vram_even_wraddr(even_addr), .vram_even_data(even_data), .vram_even_we(even_we),
        .vram_odd_wraddr(odd_addr), .vram_odd_data(odd_data), .vram_odd_we(odd_we),
        .clr_err(clr_err), .underrun(underrun), .short_line(short_line), .long_line(long_line)
    );

    typedef struct {
        logic [7:0] data;
        bit         last;
        bit         wr;
        int         line;
        int         col;
    } beat_t;
    typedef struct {
        int bank;
        int addr;
        int data;
    } wr_t;

    beat_t beats[$];
    wr_t   exp_wr[$];
    int    exp_req[$];
    int    errors = 0;
    int    checks = 0;
    int    n_writes = 0;
    bit    gaps_en = 0;
    bit    gap = 0;
    int    m_disp = 0;
    bit    m_par = 0;
    bit    m_armed = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Display position as the video timing defines it
    always @(posedge clk) begin
        if (rst) begin
            m_disp <= 0;
            m_par  <= 1'b0;
        end else if (line_advance) begin
            m_disp <= frame_start ? 0 : (m_disp + 1) % VT;
            m_par  <= frame_start ? 1'b0 : !m_par;
        end
    end

    // Pixel source
    initial forever begin
        @(posedge clk);
        #1;
        if (gap || rst || beats.size() == 0) begin
            in_valid = 1'b0;
            gap      = 1'b0;
        end else begin
            in_valid = 1'b1;
            in_data  = beats[0].data;
            in_last  = beats[0].last;
        end
    end

    // Handshake observer: pushes the expected write for each accepted pixel
    initial forever begin
        beat_t b;
        @(negedge clk);
        if (in_valid && in_ready && beats.size() > 0) begin
            b = beats.pop_front();
            if (b.wr) exp_wr.push_back('{b.line % 2, b.col, int'(b.data)});
            if (gaps_en) gap = 1'($urandom_range(0, 1));
        end
    end

    // Output monitor
    initial forever begin
        wr_t w;
        int  bank, addr, data;
        @(negedge clk);
        if (even_we || odd_we) begin
            n_writes++;
            chk("single_bank_we", int'(even_we && odd_we), 0);
            bank = odd_we ? 1 : 0;
            addr = odd_we ? int'(odd_addr) : int'(even_addr);
            data = odd_we ? int'(odd_data) : int'(even_data);
            chk("bank_isolation", bank, m_par ? 0 : 1);
            chk("write_expected", int'(exp_wr.size() > 0), 1);
            if (exp_wr.size() > 0) begin
                w = exp_wr.pop_front();
                chk("wr_bank", bank, w.bank);
                chk("wr_addr", addr, w.addr);
                chk("wr_data", data, w.data);
            end
        end
        if (line_req) begin
            chk("line_req_expected", int'(exp_req.size() > 0), 1);
            if (exp_req.size() > 0) chk("req_line", int'(req_line), exp_req.pop_front());
        end
    end

    task automatic push_beat(input int line, input int col, input logic [7:0] d,
                             input bit last, input bit wr);
        beat_t b;
        b.data = d; b.last = last; b.wr = wr; b.line = line; b.col = col;
        beats.push_back(b);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic advance();
        int nd, nt;
        bit fs;
        @(posedge clk);
        #1;
        fs = (m_disp == VT - 1);
        nd = fs ? 0 : (m_disp + 1) % VT;
        nt = (nd + 1) % VT;
        if ((m_armed || nt == 0) && nt < VP) exp_req.push_back(nt);
        if (nt == 0) m_armed = 1;
        line_advance = 1'b1;
        frame_start  = fs;
        @(posedge clk);
        #1;
        line_advance = 1'b0;
        frame_start  = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        beats.delete();
        m_armed = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic arm();
        repeat (5) begin
            advance();
            idle(3);
        end
    endtask

    task automatic wait_beats(input string name);
        int n = 0;
        while (beats.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_pixels_left"}, beats.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int w0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_line_req", line_req, 0);
        chk("rst_req_line", req_line, 0);
        chk("rst_even_we", even_we, 0);
        chk("rst_odd_we", odd_we, 0);
        chk("rst_even_addr", even_addr, 0);
        chk("rst_odd_data", odd_data, 0);
        chk("rst_flags", {underrun, short_line, long_line}, 0);

        // Nominal: two frames, first with line/col pattern data, second random
        gaps_en = 1;
        for (int f = 0; f < 2; f++)
            for (int l = 0; l < VP; l++)
                for (int c = 0; c < HP; c++)
                    push_beat(l, c, (f == 0) ? 8'(16 * l + c) : 8'($urandom), c == HP - 1, 1);
        repeat (16) begin
            advance();
            @(posedge clk);
            #1;
            frame_start = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            frame_start = 1'b0;
            idle(14);
        end
        wait_beats("nominal");
        idle(3);
        chk("nominal_writes", n_writes, 2 * VP * HP);
        chk("nominal_flags", {underrun, short_line, long_line}, 0);
        gaps_en = 0;

        // Underrun on line 1, then line 2 from column 0
        do_reset();
        arm();
        for (int c = 0; c < HP; c++) push_beat(0, c, 8'($urandom), c == HP - 1, 1);
        wait_beats("ur_line0");
        advance();
        for (int c = 0; c < 3; c++) push_beat(1, c, 8'($urandom), 0, 1);
        wait_beats("ur_head");
        idle(3);
        advance();
        chk("underrun_set", underrun, 1);
        w0 = n_writes;
        for (int c = 3; c < HP; c++) push_beat(1, c, 8'($urandom), c == HP - 1, 0);
        for (int c = 0; c < HP; c++) push_beat(2, c, 8'($urandom), c == HP - 1, 1);
        wait_beats("ur_tail");
        idle(3);
        chk("ur_writes", n_writes - w0, HP);
        chk("ur_other_flags", {short_line, long_line}, 0);

        // Short line: last at column 4
        do_reset();
        arm();
        for (int c = 0; c < 5; c++) push_beat(0, c, 8'($urandom), c == 4, 1);
        wait_beats("short");
        idle(3);
        chk("short_set", short_line, 1);
        chk("short_in_ready", in_ready, 0);
        chk("short_other_flags", {underrun, long_line}, 0);

        // Long line: 11 pixels, only 8 written, then clear
        do_reset();
        arm();
        w0 = n_writes;
        for (int c = 0; c < 11; c++) push_beat(0, c, 8'($urandom), c == 10, c < HP);
        wait_beats("long");
        idle(3);
        chk("long_writes", n_writes - w0, HP);
        chk("long_set", long_line, 1);
        @(posedge clk);
        #1;
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        @(negedge clk);
        chk("long_cleared", long_line, 0);

        // Reset after 4 pixels of line 0
        do_reset();
        arm();
        for (int c = 0; c < 4; c++) push_beat(0, c, 8'($urandom), 0, 1);
        push_beat(0, 4, 8'($urandom), 0, 0);
        while (beats.size() > 1) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_armed = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        beats.delete();
        @(negedge clk);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_we", {even_we, odd_we}, 0);
        arm();
        idle(3);

        chk("wr_queue_empty", exp_wr.size(), 0);
        chk("req_queue_empty", exp_req.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
